fir_axil_cfg_slave: RTL and testbench

- AXI-Lite responder (slave) for the FIR configuration space.
- Terminates independent AW/W/AR/R channels from the host or bench initiator.
- Holds ap_ctrl and data_length registers; writes and reads tap coefficients through the tap BRAM port.
- Hands the tap port to the FIR datapath while a run is active.

---
 rtl/fir_cfg_pkg.sv | 27 ++
 rtl/axil_hold_buf.sv | 41 ++++
 rtl/fir_axil_cfg_slave.sv | 160 ++++++++++++++++
 tb/tb_fir_axil_cfg_slave.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// Shared constants and types for the FIR AXI-Lite configuration slave.
// Address map, ap_ctrl bit positions and the read-channel state encoding.
package fir_cfg_pkg;

  localparam logic [31:0] ADDR_AP_CTRL  = 32'h00;
  localparam logic [31:0] ADDR_DATA_LEN = 32'h10;
  localparam logic [31:0] ADDR_TAP_BASE = 32'h20;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    RdIdle,
    RdAddr,
    RdWait,
    RdData
  } rd_state_e;

  // Word-aligned address inside the tap window [0x20, 0x20 + 4*num_taps).
  function automatic logic is_tap_addr(input logic [31:0] addr, input int unsigned num_taps);
    logic [31:0] off;
    off = addr - ADDR_TAP_BASE;
    return (addr >= ADDR_TAP_BASE) && (off[1:0] == 2'b00) && ((off >> 2) < num_taps);
  endfunction

endpackage

// File: rtl/axil_hold_buf.sv
// One-entry valid/ready holding register for an AXI-Lite address or data channel.
// ready pulses for a single cycle after valid is seen with the buffer empty.
module axil_hold_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             ready_o,
  input  logic             clr_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             ready_q;
  logic             full_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      ready_q <= valid_i && !full_q && !ready_q;
      // A handshake can only happen while empty, so it never collides with clr_i.
      if (valid_i && ready_q) begin
        full_q <= 1'b1;
        data_q <= data_i;
      end else if (clr_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign ready_o = ready_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fir_axil_cfg_slave.sv
// AXI-Lite configuration slave for the FIR: ap_ctrl, data_length and tap coefficient access.
// The tap BRAM port is shared with the datapath, which owns it whenever a run is active.
module fir_axil_cfg_slave
  import fir_cfg_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [pDATA_WIDTH-1:0] wdata,
  output logic                   wready,
  input  logic                   arvalid,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   arready,
  input  logic                   rready,
  output logic                   rvalid,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  input  logic [pADDR_WIDTH-1:0] eng_tap_A,
  output logic                   ap_start_o,
  input  logic                   eng_done,
  output logic [pDATA_WIDTH-1:0] data_length_o
);

  logic                   aw_full, w_full, commit;
  logic [pADDR_WIDTH-1:0] aw_addr;
  logic [pDATA_WIDTH-1:0] w_data;
  logic                   cm_ctrl, cm_len, cm_tap, rd_clr;

  logic                   ap_start_q, ap_done_q, ap_idle_q;
  logic [pDATA_WIDTH-1:0] data_length_q;
  rd_state_e              rd_state_q, rd_state_d;
  logic [pADDR_WIDTH-1:0] ar_addr_q;
  logic [pDATA_WIDTH-1:0] rdata_q, rd_mux;

  axil_hold_buf #(.Width(pADDR_WIDTH)) u_aw_buf (
    .clk_i   (axis_clk),
    .rst_ni  (axis_rst_n),
    .valid_i (awvalid),
    .data_i  (awaddr),
    .ready_o (awready),
    .clr_i   (commit),
    .full_o  (aw_full),
    .data_o  (aw_addr)
  );

  axil_hold_buf #(.Width(pDATA_WIDTH)) u_w_buf (
    .clk_i   (axis_clk),
    .rst_ni  (axis_rst_n),
    .valid_i (wvalid),
    .data_i  (wdata),
    .ready_o (wready),
    .clr_i   (commit),
    .full_o  (w_full),
    .data_o  (w_data)
  );

  assign commit  = aw_full && w_full;
  assign cm_ctrl = commit && (32'(aw_addr) == ADDR_AP_CTRL);
  assign cm_len  = commit && (32'(aw_addr) == ADDR_DATA_LEN);
  // Tap writes during a run are dropped: the datapath owns the port.
  assign cm_tap  = commit && ap_idle_q && is_tap_addr(32'(aw_addr), Tape_Num);
  assign rd_clr  = (rd_state_q == RdData) && rready && (32'(ar_addr_q) == ADDR_AP_CTRL);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      ap_start_q    <= 1'b0;
      ap_done_q     <= 1'b0;
      ap_idle_q     <= 1'b1;
      data_length_q <= '0;
    end else begin
      ap_start_q <= cm_ctrl && w_data[0] && ap_idle_q;
      if (cm_ctrl && w_data[0] && ap_idle_q) ap_idle_q <= 1'b0;
      if (cm_len) data_length_q <= w_data;
      // Completion wins over a coincident clear-on-read.
      if (eng_done) begin
        ap_done_q <= 1'b1;
        ap_idle_q <= 1'b1;
      end else if (rd_clr) begin
        ap_done_q <= 1'b0;
      end
    end
  end

  // Read FSM: state register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rd_state_q <= RdIdle;
      ar_addr_q  <= '0;
      rdata_q    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_state_q == RdAddr && !cm_tap) ar_addr_q <= araddr;
      if (rd_state_q == RdWait) rdata_q <= rd_mux;
    end
  end

  // Read FSM: next state
  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RdIdle:  if (arvalid) rd_state_d = RdAddr;
      RdAddr:  if (!cm_tap) rd_state_d = RdWait;
      RdWait:  rd_state_d = RdData;
      RdData:  if (rready) rd_state_d = RdIdle;
      default: rd_state_d = RdIdle;
    endcase
  end

  // Read data selection, sampled on the RdWait -> RdData transition.
  always_comb begin
    rd_mux = '0;
    if (32'(ar_addr_q) == ADDR_AP_CTRL) begin
      rd_mux[AP_START_BIT] = ap_start_q;
      rd_mux[AP_DONE_BIT]  = ap_done_q;
      rd_mux[AP_IDLE_BIT]  = ap_idle_q;
    end else if (32'(ar_addr_q) == ADDR_DATA_LEN) begin
      rd_mux = data_length_q;
    end else if (is_tap_addr(32'(ar_addr_q), Tape_Num)) begin
      rd_mux = ap_idle_q ? tap_Do : '1;
    end
  end

  // Read FSM outputs and tap port arbitration: datapath > commit write > host read.
  always_comb begin
    arready = (rd_state_q == RdAddr) && !cm_tap;
    rvalid  = (rd_state_q == RdData);
    tap_EN  = 1'b0;
    tap_WE  = 4'h0;
    tap_A   = '0;
    tap_Di  = '0;
    if (!ap_idle_q) begin
      tap_EN = 1'b1;
      tap_A  = eng_tap_A;
    end else if (cm_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = pADDR_WIDTH'(32'(aw_addr) - ADDR_TAP_BASE);
      tap_Di = w_data;
    end else if (rd_state_q == RdAddr) begin
      tap_EN = 1'b1;
      tap_A  = pADDR_WIDTH'(32'(araddr) - ADDR_TAP_BASE);
    end
  end

  assign rdata         = rdata_q;
  assign ap_start_o    = ap_start_q;
  assign data_length_o = data_length_q;

endmodule

// File: tb/tb_fir_axil_cfg_slave.sv
// Randomised scoreboard bench for fir_axil_cfg_slave against a register-level model.
// A BRAM model backs the tap port; a monitor checks R beats, tap writes and start pulses.
module tb_fir_axil_cfg_slave;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NT = 11;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0, eng_tap_A = '0;
  logic [DW-1:0] wdata = '0, tap_Do = '0;
  logic          eng_done = 1'b0;
  logic          awready, wready, arready, rvalid, tap_EN, ap_start_o;
  logic [DW-1:0] rdata, tap_Di, data_length_o;
  logic [3:0]    tap_WE;
  logic [AW-1:0] tap_A;

  fir_axil_cfg_slave #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
    .axis_clk      (axis_clk),
    .axis_rst_n    (axis_rst_n),
    .awvalid       (awvalid),
    .awaddr        (awaddr),
    .awready       (awready),
    .wvalid        (wvalid),
    .wdata         (wdata),
    .wready        (wready),
    .arvalid       (arvalid),
    .araddr        (araddr),
    .arready       (arready),
    .rready        (rready),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .tap_WE        (tap_WE),
    .tap_EN        (tap_EN),
    .tap_A         (tap_A),
    .tap_Di        (tap_Di),
    .tap_Do        (tap_Do),
    .eng_tap_A     (eng_tap_A),
    .ap_start_o    (ap_start_o),
    .eng_done      (eng_done),
    .data_length_o (data_length_o)
  );

  always #5 axis_clk = ~axis_clk;

  // Tap BRAM: byte address, one-cycle read latency.
  logic [DW-1:0] bram [0:15];
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) bram[tap_A[5:2]] <= tap_Di;
      tap_Do <= bram[tap_A[5:2]];
    end
  end

  int n_cmp = 0, n_err = 0;
  int seen_start = 0, exp_start = 0;
  logic [DW-1:0]    exp_r[$];
  logic [AW+DW-1:0] exp_tap[$];

  // Reference model state.
  logic [DW-1:0] m_len = '0;
  logic          m_idle = 1'b1, m_done = 1'b0;
  logic [DW-1:0] m_taps [0:NT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_is_tap(input logic [AW-1:0] a);
    int off;
    off = int'(a) - 32;
    return off >= 0 && (off % 4) == 0 && (off / 4) < NT;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    if (a == 12'h000) begin
      v = {29'd0, m_idle, m_done, 1'b0};
      m_done = 1'b0;
    end else if (a == 12'h010) v = m_len;
    else if (m_is_tap(a)) v = m_idle ? m_taps[(int'(a) - 32) / 4] : 32'hFFFF_FFFF;
    return v;
  endfunction

  // Returns 1 when the write is expected to drive the tap port.
  function automatic bit model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (a == 12'h000) begin
      if (d[0] && m_idle) begin
        exp_start++;
        m_idle = 1'b0;
      end
    end else if (a == 12'h010) m_len = d;
    else if (m_is_tap(a) && m_idle) begin
      m_taps[(int'(a) - 32) / 4] = d;
      exp_tap.push_back({a - 12'h020, d});
      return 1'b1;
    end
    return 1'b0;
  endfunction

  always @(negedge axis_clk) begin
    if (axis_rst_n) begin
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL r_unexpected: got rdata %0h with no read outstanding", rdata);
        end else check("r_data", rdata, exp_r.pop_front());
      end
      if (tap_EN && tap_WE != 4'h0) begin
        if (exp_tap.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tap_unexpected: got WE %0h A %0h Di %0h", tap_WE, tap_A, tap_Di);
        end else check("tap_write", {tap_WE, tap_A, tap_Di}, {4'hF, exp_tap.pop_front()});
      end
      if (ap_start_o) seen_start++;
    end
  end

  task automatic aw_send(input logic [AW-1:0] a);
    int n;
    n = 0;
    awvalid = 1'b1; awaddr = a;
    do begin @(negedge axis_clk); n++; end while (!awready && n < 10);
    check("aw_ready_seen", awready, 1'b1);
    @(posedge axis_clk); #1 awvalid = 1'b0;
  endtask

  // Optionally raises AR in the W handshake cycle so AR lands on the commit cycle.
  task automatic w_send(input logic [DW-1:0] d, input bit raise_ar, input logic [AW-1:0] ar_a);
    int n;
    n = 0;
    wvalid = 1'b1; wdata = d;
    do begin @(negedge axis_clk); n++; end while (!wready && n < 10);
    check("w_ready_seen", wready, 1'b1);
    if (raise_ar) begin
      arvalid = 1'b1; araddr = ar_a;
    end
    @(posedge axis_clk); #1 wvalid = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit w_first, input int gap);
    bit is_tap;
    if (w_first) w_send(d, 1'b0, '0); else aw_send(a);
    repeat (gap) begin @(posedge axis_clk); #1; end
    if (w_first) aw_send(a); else w_send(d, 1'b0, '0);
    is_tap = model_write(a, d);
    @(negedge axis_clk);
    check("commit_latency", tap_WE, is_tap ? 4'hF : 4'h0);
    @(negedge axis_clk);
    check("data_length", data_length_o, m_len);
    @(posedge axis_clk); #1;
  endtask

  task automatic rd_issue(input logic [AW-1:0] a);
    arvalid = 1'b1; araddr = a;
    exp_r.push_back(model_read(a));
  endtask

  // Waits for rvalid, holds rready low for 'hold' cycles, then optionally completes R.
  task automatic rd_collect(input logic [DW-1:0] e, input int hold, input bit finish);
    int k, ar_k;
    bit hs;
    ar_k = -1;
    for (k = 0; k < 30; k++) begin
      @(negedge axis_clk);
      if (rvalid) break;
      hs = arready;
      if (hs && ar_k < 0) ar_k = k;
      @(posedge axis_clk); #1;
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    check("ar_latency", ar_k, 1);
    check("r_latency", k, 3);
    for (int h = 0; h < hold; h++) begin
      @(posedge axis_clk); #1;
      @(negedge axis_clk);
      check("r_hold", {rvalid, rdata}, {1'b1, e});
    end
    if (finish) begin
      @(posedge axis_clk); #1 rready = 1'b1;
      @(posedge axis_clk); #1 rready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int hold);
    rd_issue(a);
    rd_collect(exp_r[exp_r.size()-1], hold, 1'b1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, {awready, wready, arready, rvalid}, 4'h0);
    check({tag, "_tap"}, {tap_EN, tap_WE, ap_start_o}, 6'h0);
    check({tag, "_rdata"}, rdata, '0);
    check({tag, "_len"}, data_length_o, '0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int r;
    bit unused;
    for (int i = 0; i < 16; i++) bram[i] = '0;
    for (int i = 0; i < NT; i++) m_taps[i] = '0;

    #23;
    check_reset_state("rst_hold");
    @(negedge axis_clk) axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    check_reset_state("rst_exit");
    axi_read(12'h000, 0);

    // Fixed tap write in both channel orders.
    axi_write(12'h024, 32'hFFFF_FFF6, 1'b0, 3);
    axi_write(12'h024, 32'hFFFF_FFF6, 1'b1, 3);
    axi_write(12'h010, 32'd600, 1'b0, 0);
    axi_read(12'h010, 5);
    axi_read(12'h024, 0);

    // Randomised traffic while idle, including out-of-window addresses.
    for (int it = 0; it < 30; it++) begin
      r = $urandom_range(0, 5);
      d = $urandom;
      case (r)
        0: a = 12'h010;
        1, 2: a = 12'(32 + 4 * $urandom_range(0, NT - 1));
        3: begin
          r = $urandom_range(0, 3);
          a = (r == 0) ? 12'h014 : (r == 1) ? 12'h04C : (r == 2) ? 12'h004 : 12'h100;
        end
        default: a = '0;
      endcase
      if (a != 12'h000) axi_write(a, d, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
      else begin
        r = $urandom_range(0, 4);
        a = (r == 0) ? 12'h000 : (r == 1) ? 12'h010 : (r == 2) ? 12'h04C :
            12'(32 + 4 * $urandom_range(0, NT - 1));
        axi_read(a, $urandom_range(0, 2));
      end
    end

    // Start a run and exercise the busy window.
    axi_write(12'h000, 32'h1, 1'b0, 1);
    axi_read(12'h000, 0);
    axi_write(12'h028, 32'd5, 1'b1, 0);
    axi_read(12'h028, 0);
    axi_write(12'h000, 32'h1, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      eng_tap_A = 12'(4 * $urandom_range(0, NT - 1));
      @(negedge axis_clk);
      check("busy_tap_port", {tap_EN, tap_WE, tap_A}, {1'b1, 4'h0, eng_tap_A});
      @(posedge axis_clk); #1;
    end
    eng_done = 1'b1;
    @(posedge axis_clk); #1 eng_done = 1'b0;
    m_done = 1'b1; m_idle = 1'b1;
    axi_read(12'h000, 0);
    axi_read(12'h000, 0);
    check("start_pulses", seen_start, exp_start);

    // AR arriving on a tap commit cycle must yield to the write and read its result.
    d = $urandom;
    aw_send(12'h030);
    unused = model_write(12'h030, d);
    exp_r.push_back(model_read(12'h030));
    w_send(d, 1'b1, 12'h030);
    rd_collect(d, 0, 1'b1);

    // Asynchronous reset in the middle of RdData.
    axi_write(12'h010, 32'h1234_5678, 1'b1, 2);
    rd_issue(12'h010);
    rd_collect(32'h1234_5678, 1, 1'b0);
    #2 axis_rst_n = 1'b0;
    #1;
    check_reset_state("rst_async");
    exp_r.delete();
    m_len = '0; m_idle = 1'b1; m_done = 1'b0;
    @(negedge axis_clk) axis_rst_n = 1'b1;
    @(posedge axis_clk); #1;
    axi_read(12'h000, 0);
    axi_read(12'h010, 0);
    repeat (3) @(posedge axis_clk);
    check("r_drain", exp_r.size(), 0);
    check("tap_drain", exp_tap.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
